// File: rtl/sparc_mem_pkg.sv
// Shared memory-side definitions for the SPARC DataPath RAM loader.
// Holds the loader state encoding and word/byte address helpers.
package sparc_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WRITE      = 3'd2,
        ST_VERIFY_RD  = 3'd3,
        ST_VERIFY_CMP = 3'd4,
        ST_NEXT       = 3'd5,
        ST_DONE       = 3'd6
    } state_e;

    function automatic logic [31:0] word_to_byte(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + WORD_BYTES * idx;
    endfunction

endpackage

// File: rtl/start_edge_det.sv
// Registered rising-edge detector: one-cycle pulse the cycle after
// the input is first seen high.
module start_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            rise_q <= sig_i & ~sig_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/ram_image_loader.sv
// Copies an image from a synchronous ROM into the DataPath RAM on precharge,
// stalling the DataPath until resident. READBACK_VERIFY_EN adds readback check.
module ram_image_loader
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int IMG_WORDS = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              precharge,
    output logic [ADDR_W-3:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              hold,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start;

`ifdef READBACK_VERIFY_EN
    logic              err_q, err_d;
`endif

    start_edge_det u_start (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (precharge),
        .rise_o (start)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
`ifdef READBACK_VERIFY_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                idx_d = '0;
                if (start) begin
                    state_d = ST_FETCH;
`ifdef READBACK_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                wdata_d = img_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (ram_ready) begin
`ifdef READBACK_VERIFY_EN
                    state_d = ST_VERIFY_RD;
`else
                    state_d = ST_NEXT;
`endif
                end
            end
`ifdef READBACK_VERIFY_EN
            ST_VERIFY_RD: begin
                state_d = ST_VERIFY_CMP;
            end
            ST_VERIFY_CMP: begin
                if (ram_rdata != wdata_q) begin
                    err_d = 1'b1;
                end
                state_d = ST_NEXT;
            end
`endif
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef READBACK_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign err = 1'b0;
`endif

    // ROM address leads by a cycle so its registered data is valid in FETCH
    assign img_addr  = idx_d;
    assign ram_addr  = ADDR_W'(word_to_byte(32'(BASE_ADDR), 32'(idx_q)));
    assign ram_wdata = wdata_q;
    assign ram_we    = (state_q == ST_WRITE);
    assign hold      = (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);

endmodule
